// File: rtl/control_pkg.sv
// control_pkg: shared encodings for the multi-cycle RV32I-subset control unit.
package control_pkg;
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WBACK  = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1100;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam int SB_N = 3;
  localparam int SB_Z = 2;
  localparam int SB_C = 1;
  localparam int SB_V = 0;
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic sub);
    return sub ? ALU_SUB :
           f3 == 3'b111 ? ALU_AND :
           f3 == 3'b110 ? ALU_OR :
           f3 == 3'b100 ? ALU_XOR :
           f3 == 3'b010 ? ALU_SLT :
           f3 == 3'b011 ? ALU_SLTU : ALU_ADD;
  endfunction
endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: control <-> datapath signal bundle; master is the control unit.
interface control_fsm_if #(parameter int RET_W = 16);
  logic [31:0]      Instr;
  logic [3:0]       Status;
  logic [1:0]       imm_sel;
  logic             RegRW;
  logic             ALUsrc;
  logic [3:0]       ALUop;
  logic             MRW;
  logic             WB;
  logic             PCsrc;
  logic             PCen;
  logic             trap;
  logic [RET_W-1:0] retired;
  modport master(input Instr, Status,
                 output imm_sel, RegRW, ALUsrc, ALUop, MRW, WB, PCsrc, PCen, trap, retired);
  modport slave(output Instr, Status,
                input imm_sel, RegRW, ALUsrc, ALUop, MRW, WB, PCsrc, PCen, trap, retired);
endinterface

// File: rtl/branch_cond.sv
// branch_cond: branch-taken decision from funct3 and the {N,Z,C,V} flags of rs1-rs2.
module branch_cond import control_pkg::*; (
  input  logic [2:0] i_funct3,
  input  logic [3:0] i_status,
  output logic       o_taken
);
  logic w_lt;
  logic w_base;
  assign w_lt = i_status[SB_N] ^ i_status[SB_V];
  // funct3[0] inverts the base test; 010/011 are not branches
  assign w_base = i_funct3[2] ? (i_funct3[1] ? !i_status[SB_C] : w_lt) : i_status[SB_Z];
  assign o_taken = (w_base ^ i_funct3[0]) & !(!i_funct3[2] & i_funct3[1]);
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control sequencer producing one-cycle write strobes,
// a PC update strobe, a sticky illegal-instruction trap and a retire counter.
module control_fsm import control_pkg::*; #(
  parameter int RET_W = 16
) (
  input logic          clk,
  input logic          reset,
  control_fsm_if.master bus
);
  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [31:0]      r_ir;
  logic [RET_W-1:0] r_ret;
  logic [6:0]       w_op;
  logic [2:0]       w_f3;
  logic w_r, w_i, w_lw, w_sw, w_br;
  logic w_legal, w_taken, w_pcen;
  logic w_exec, w_mem, w_wb;
  logic w_unused;
  assign w_op = r_ir[6:0];
  assign w_f3 = r_ir[14:12];
  assign w_r  = w_op == OP_R;
  assign w_i  = w_op == OP_I;
  assign w_lw = w_op == OP_LW;
  assign w_sw = w_op == OP_SW;
  assign w_br = w_op == OP_BR;
  assign w_unused = ^{r_ir[31], r_ir[29:15], r_ir[11:7]};
  // shifts are not supported by the datapath; funct3 010/011 are not branches
  assign w_legal = ((w_r | w_i) & w_f3 != 3'b001 & w_f3 != 3'b101) |
                   (w_lw & w_f3 == 3'b010) | w_sw |
                   (w_br & !(!w_f3[2] & w_f3[1]));
  branch_cond u_branch_cond (
    .i_funct3(w_f3),
    .i_status(bus.Status),
    .o_taken (w_taken)
  );
  always_comb begin
    w_next = r_state == ST_FETCH  ? ST_DECODE :
             r_state == ST_DECODE ? (w_legal ? ST_EXEC : ST_TRAP) :
             r_state == ST_EXEC   ? (w_br ? ST_FETCH : (w_lw | w_sw) ? ST_MEM : ST_WBACK) :
             r_state == ST_MEM    ? (w_lw ? ST_WBACK : ST_FETCH) :
             r_state == ST_WBACK  ? ST_FETCH : ST_TRAP;
  end
  assign w_exec = r_state == ST_EXEC;
  assign w_mem  = r_state == ST_MEM;
  assign w_wb   = r_state == ST_WBACK;
  assign w_pcen = (w_exec & w_br) | (w_mem & w_sw) | w_wb;
  assign bus.imm_sel = w_exec ? (w_sw ? IMM_S : w_br ? IMM_B : IMM_I) : IMM_I;
  assign bus.ALUsrc  = w_exec & (w_i | w_lw | w_sw);
  assign bus.ALUop   = (!w_exec | w_lw | w_sw) ? ALU_ADD : w_br ? ALU_SUB : alu_dec(w_f3, w_r & r_ir[30]);
  assign bus.MRW     = w_mem & w_sw;
  assign bus.RegRW   = w_wb;
  assign bus.WB      = !(w_wb & w_lw);
  assign bus.PCsrc   = w_exec & w_br & w_taken;
  assign bus.PCen    = w_pcen;
  assign bus.trap    = r_state == ST_TRAP;
  assign bus.retired = r_ret;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
      r_ret   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH) r_ir <= bus.Instr;
      r_ret <= r_ret + RET_W'(w_pcen);
    end
  end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: random instruction stream checked against a mnemonic-level model,
// scoreboarded on each PC update, plus trap and mid-instruction reset scenarios.
module tb_control_fsm;
  localparam int RW = 6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  control_fsm_if #(.RET_W(RW)) bus();
  control_fsm #(.RET_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] imm;
    logic       src;
    logic [3:0] op;
    logic       regrw;
    logic       mrw;
    logic       wb;
    logic       pcsrc;
    int         cpi;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int n_cmp = 0;
  int n_bad = 0;
  int idx = 0;
  bit mon_en = 1'b0;
  logic [RW-1:0] exp_ret = '0;
  logic [6:0] ops [5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
  logic [2:0] alu_f3 [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [3:0] flags(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d = a - b;
    return {d[31], d == 32'd0, a >= b, (a[31] ^ b[31]) & (d[31] ^ a[31])};
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [2:0] f3 = ins[14:12];
    logic [6:0] op = ins[6:0];
    e = '{imm: 2'b00, src: 1'b0, op: 4'b0100, regrw: 1'b0, mrw: 1'b0, wb: 1'b1, pcsrc: 1'b0, cpi: 4};
    if (op == 7'h33 || op == 7'h13) begin
      e.regrw = 1'b1;
      e.src = op == 7'h13;
      e.op = f3 == 3'd0 ? ((op == 7'h33 && ins[30]) ? 4'b1100 : 4'b0100) :
             f3 == 3'd2 ? 4'b0111 : f3 == 3'd3 ? 4'b0110 :
             f3 == 3'd4 ? 4'b0011 : f3 == 3'd6 ? 4'b0001 : 4'b0000;
    end else if (op == 7'h03) begin
      e.src = 1'b1; e.regrw = 1'b1; e.wb = 1'b0; e.cpi = 5;
    end else if (op == 7'h23) begin
      e.src = 1'b1; e.imm = 2'b01; e.mrw = 1'b1;
    end else begin
      e.imm = 2'b10; e.op = 4'b1100; e.cpi = 3;
      e.pcsrc = f3 == 3'd0 ? a == b : f3 == 3'd1 ? a != b :
                f3 == 3'd4 ? $signed(a) < $signed(b) : f3 == 3'd5 ? $signed(a) >= $signed(b) :
                f3 == 3'd6 ? a < b : a >= b;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] ins = $urandom;
    int c = $urandom_range(0, 4);
    ins[6:0] = ops[c];
    ins[14:12] = c < 2 ? alu_f3[$urandom_range(0, 5)] : c == 4 ? br_f3[$urandom_range(0, 5)] : 3'd2;
    if (c == 0) ins[31:25] = (ins[14:12] == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return ins;
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    exp_t e = model(ins, a, b);
    bus.Instr = ins;
    bus.Status = flags(a, b);
    q.push_back(e);
    repeat (e.cpi) @(negedge clk);
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (!mon_en) idx = 0;
    else begin
      chk("strobe_gate", 32'(((bus.RegRW | bus.MRW) & !bus.PCen) | (bus.RegRW & bus.MRW) | bus.trap), 32'd0);
      if (q.size() == 0) chk("unexpected_pcen", 32'(bus.PCen), 32'd0);
      else begin
        me = q[0];
        if (idx < 2)
          chk("idle_ctrl", 32'({bus.imm_sel, bus.ALUsrc, bus.ALUop, bus.WB, bus.PCsrc}), 32'({2'b00, 1'b0, 4'b0100, 1'b1, 1'b0}));
        if (idx == 2)
          chk("exec_ctrl", 32'({bus.imm_sel, bus.ALUsrc, bus.ALUop}), 32'({me.imm, me.src, me.op}));
        if (bus.PCen) begin
          chk("retire_ctrl", 32'({bus.RegRW, bus.MRW, bus.WB, bus.PCsrc}), 32'({me.regrw, me.mrw, me.wb, me.pcsrc}));
          chk("cpi", 32'(idx + 1), 32'(me.cpi));
          chk("retired", 32'(bus.retired), 32'(exp_ret));
          exp_ret++;
          void'(q.pop_front());
          idx = 0;
        end else if (idx >= 7) begin
          chk("retire_by", 32'(idx), 32'(me.cpi - 1));
          void'(q.pop_front());
          idx = 0;
        end else idx++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic [RW-1:0] ret_hold;
    bus.Instr = 32'd0;
    bus.Status = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_idle", 32'({bus.PCen, bus.RegRW, bus.MRW, bus.WB, bus.trap, bus.ALUop}), 32'({4'b0001, 1'b0, 4'b0100}));
    chk("reset_retired", 32'(bus.retired), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    issue(32'h00450693, $urandom, $urandom);
    issue(32'h0006A803, $urandom, $urandom);
    issue(32'hFE322FA3, $urandom, $urandom);
    issue({7'd0, 5'd11, 5'd14, 3'b110, 5'd0, 7'b1100011}, 32'd0, 32'h80000001);
    issue({7'd0, 5'd11, 5'd14, 3'b110, 5'd0, 7'b1100011}, 32'd2, 32'd1);
    repeat (200) begin
      a = $urandom;
      b = $urandom_range(0, 3) == 0 ? a : $urandom;
      issue(rand_ins(), a, b);
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    ret_hold = bus.retired;
    bus.Instr = 32'h0000007F;
    #1;
    chk("trap_fetch", 32'(bus.trap), 32'd0);
    @(negedge clk);
    #1;
    chk("trap_decode", 32'(bus.trap), 32'd0);
    repeat (20) begin
      @(negedge clk);
      #1;
      chk("trap_held", 32'(bus.trap), 32'd1);
      chk("trap_enables", 32'({bus.RegRW, bus.MRW, bus.PCen}), 32'd0);
      chk("trap_retired", 32'(bus.retired), 32'(ret_hold));
    end
    reset = 1'b1;
    #1;
    chk("trap_cleared", 32'(bus.trap), 32'd0);
    chk("trap_rst_retired", 32'(bus.retired), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.Instr = 32'h00450693;
    repeat (4) @(negedge clk);
    bus.Instr = 32'h003100B3;
    repeat (3) @(negedge clk);
    #1;
    chk("add_wback", 32'({bus.RegRW, bus.PCen, bus.WB}), 32'b111);
    chk("add_pre_retired", 32'(bus.retired), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_idle", 32'({bus.RegRW, bus.PCen, bus.MRW, bus.WB}), 32'b0001);
    chk("rst_mid_retired", 32'(bus.retired), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      #1;
      chk("post_rst_no_write", 32'({bus.RegRW, bus.MRW, bus.PCen}), 32'd0);
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
